// File: rtl/led_pkg.sv
// Shared register-map and decode definitions for the LED bank controller.
// Offsets scale with NW, the number of bus words per LED-wide register.
package led_pkg;

  typedef enum logic [2:0] {
    SEL_PATTERN,
    SEL_BLINK,
    SEL_RATE,
    SEL_DUTY,
    SEL_NONE
  } reg_sel_e;

  localparam logic [15:0] RATE_RST     = 16'h0;
  localparam logic [7:0]  DUTY_RST     = 8'hFF;
  localparam int          PATTERN_BASE = 0;

  function automatic int blink_base(int nw);
    return nw;
  endfunction

  function automatic int rate_ofs(int nw);
    return 2 * nw;
  endfunction

  function automatic int duty_ofs(int nw);
    return 2 * nw + 1;
  endfunction

  // DUTY decodes only when the PWM build is selected; otherwise it is a hole.
  function automatic reg_sel_e decode_sel(int a, int nw, bit duty_en);
    if (a >= PATTERN_BASE && a < blink_base(nw)) return SEL_PATTERN;
    if (a >= blink_base(nw) && a < rate_ofs(nw))  return SEL_BLINK;
    if (a == rate_ofs(nw))                        return SEL_RATE;
    if (duty_en && a == duty_ofs(nw))             return SEL_DUTY;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Blink prescaler: phase toggles every RATE+1 cycles; RATE=0 holds it at 0.
// A RATE write restarts the count and phase, winning over a coincident wrap.
module led_blink_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rate_i,
  input  logic        rate_wr_i,
  output logic        phase_o
);

  logic [15:0] cnt_q;
  logic        phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 16'h0;
      phase_q <= 1'b0;
    end else if (rate_wr_i || rate_i == 16'h0) begin
      cnt_q   <= 16'h0;
      phase_q <= 1'b0;
    end else if (cnt_q == rate_i) begin
      cnt_q   <= 16'h0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 16'd1;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/led_bank_ctrl.sv
// Memory-mapped LED bank: byte-enabled PATTERN/BLINK/RATE registers, 1-cycle readback.
// Optional global PWM brightness (DUTY register) is built when LED_PWM_EN is defined.
module led_bank_ctrl
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 24,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic [NUM_LEDS-1:0]   led_out
);

  localparam int NW         = (NUM_LEDS + DATA_W - 1) / DATA_W;
  localparam int REG_W      = NW * DATA_W;
  localparam int NB         = DATA_W / 8;
  localparam int BLINK_BASE = blink_base(NW);
`ifdef LED_PWM_EN
  localparam bit DUTY_EN = 1'b1;
`else
  localparam bit DUTY_EN = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] merge(logic [DATA_W-1:0] old_v,
                                               logic [DATA_W-1:0] new_v,
                                               logic [NB-1:0]     en);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < NB; i++) begin
      if (en[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  logic [NUM_LEDS-1:0] pattern_q, pattern_d;
  logic [NUM_LEDS-1:0] blink_q, blink_d;
  logic [15:0]         rate_q, rate_d;
  logic [DATA_W-1:0]   rdata_q, rd_word;
  logic                rvalid_q;
  logic [NUM_LEDS-1:0] led_q, led_d, base;
  logic                phase;
  logic                rate_wr;
  reg_sel_e            sel;
  int                  widx;
  logic [REG_W-1:0]    pat_w, blk_w;
  logic [DATA_W-1:0]   rate_w;

  always_comb begin
    sel  = decode_sel(int'(addr), NW, DUTY_EN);
    widx = 0;
    if (sel == SEL_PATTERN)    widx = int'(addr) - PATTERN_BASE;
    else if (sel == SEL_BLINK) widx = int'(addr) - BLINK_BASE;
  end

  assign rate_wr = we && (sel == SEL_RATE);

  // Registers are zero-extended to whole bus words so out-of-range bits drop on write and read as 0.
  always_comb begin
    pat_w  = REG_W'(pattern_q);
    blk_w  = REG_W'(blink_q);
    rate_w = merge(DATA_W'(rate_q), wdata, be);
    if (we && sel == SEL_PATTERN)
      pat_w[widx*DATA_W +: DATA_W] = merge(pat_w[widx*DATA_W +: DATA_W], wdata, be);
    if (we && sel == SEL_BLINK)
      blk_w[widx*DATA_W +: DATA_W] = merge(blk_w[widx*DATA_W +: DATA_W], wdata, be);
    pattern_d = pat_w[NUM_LEDS-1:0];
    blink_d   = blk_w[NUM_LEDS-1:0];
    rate_d    = rate_wr ? 16'(rate_w) : rate_q;
  end

`ifdef LED_PWM_EN
  logic [7:0]        duty_q, duty_d;
  logic [7:0]        pwm_cnt_q;
  logic [DATA_W-1:0] duty_w;

  always_comb begin
    duty_w = merge(DATA_W'(duty_q), wdata, be);
    duty_d = (we && sel == SEL_DUTY) ? duty_w[7:0] : duty_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q    <= DUTY_RST;
      pwm_cnt_q <= 8'h0;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end
`endif

  // Reads sample the registers before this edge's write lands.
  always_comb begin
    rd_word = '0;
    case (sel)
      SEL_PATTERN: rd_word = REG_W'(pattern_q) >> (widx * DATA_W);
      SEL_BLINK:   rd_word = REG_W'(blink_q) >> (widx * DATA_W);
      SEL_RATE:    rd_word = DATA_W'(rate_q);
`ifdef LED_PWM_EN
      SEL_DUTY:    rd_word = DATA_W'(duty_q);
`endif
      default:     rd_word = '0;
    endcase
  end

  led_blink_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .rate_i    (rate_q),
    .rate_wr_i (rate_wr),
    .phase_o   (phase)
  );

  assign base = pattern_q ^ (blink_q & {NUM_LEDS{phase}});

`ifdef LED_PWM_EN
  assign led_d = base & {NUM_LEDS{pwm_cnt_q < duty_q}};
`else
  assign led_d = base;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= '0;
      blink_q   <= '0;
      rate_q    <= RATE_RST;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      led_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      blink_q   <= blink_d;
      rate_q    <= rate_d;
      rvalid_q  <= re;
      if (re) rdata_q <= rd_word;
      led_q     <= led_d;
    end
  end

  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_led_bank_ctrl.sv
// Directed bench for led_bank_ctrl; read data is checked against a queue of expected words.
// Build with LED_PWM_EN defined to exercise the PWM brightness path.
module tb_led_bank_ctrl;

  logic        clk;
  logic        rst;
  logic        we;
  logic        re;
  logic [3:0]  addr;
  logic [1:0]  be;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid;
  logic [23:0] led_out;

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb[$];

  led_bank_ctrl #(.NUM_LEDS(24), .DATA_W(16), .ADDR_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .re      (re),
    .addr    (addr),
    .be      (be),
    .wdata   (wdata),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .led_out (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
    we = 1'b1; addr = a; wdata = d; be = b;
    cyc();
    we = 1'b0; be = 2'b00;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp);
    re = 1'b1; addr = a;
    sb.push_back(exp);
    cyc();
    re = 1'b0;
    cyc();
    chk("rvalid_pulse", 32'(rvalid), 32'h0);
  endtask

  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL rdata_unexpected observed=%h expected=no_read", rdata);
      end else begin
        chk("rdata", 32'(rdata), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    logic [23:0] e;
    int on;
    int waited;
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; be = '0; wdata = '0;
    repeat (3) cyc();
    chk("reset_led", 32'(led_out), 32'h0);
    chk("reset_rdata", 32'(rdata), 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    rst = 1'b0;
    cyc();

    // Byte-lane write and write-to-LED latency
    wr(4'd0, 16'hA5C3, 2'b01);
    chk("led_latency", 32'(led_out), 32'h0);
    cyc();
    chk("led_lane0", 32'(led_out), 32'h0000C3);
    rd(4'd0, 16'h00C3);

    // Bits above NUM_LEDS are dropped
    wr(4'd1, 16'hFFFF, 2'b11);
    cyc();
    chk("led_top", 32'(led_out), 32'hFF00C3);
    rd(4'd1, 16'h00FF);

    // Blink with RATE=3: period 8, phase flips after every 4th edge
    wr(4'd0, 16'h0000, 2'b11);
    wr(4'd1, 16'h0000, 2'b11);
    wr(4'd2, 16'h000F, 2'b11);
    wr(4'd4, 16'h0003, 2'b11);
    for (int k = 1; k <= 22; k++) begin
      cyc();
      e = ((((k - 1) / 4) % 2) == 1) ? 24'h00000F : 24'h0;
      chk("blink_run", 32'(led_out), 32'(e));
    end
    wr(4'd4, 16'h0003, 2'b11);
    chk("blink_pre_restart", 32'(led_out), 32'h00000F);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      e = ((((k - 1) / 4) % 2) == 1) ? 24'h00000F : 24'h0;
      chk("blink_restart", 32'(led_out), 32'(e));
    end
    rd(4'd4, 16'h0003);
    rd(4'd2, 16'h000F);
    wr(4'd3, 16'hFFFF, 2'b11);
    rd(4'd3, 16'h00FF);
    wr(4'd4, 16'h0000, 2'b11);
    wr(4'd2, 16'h0000, 2'b11);
    wr(4'd3, 16'h0000, 2'b11);
    cyc();
    chk("blink_off", 32'(led_out), 32'h0);

    // Unmapped address
    wr(4'hF, 16'hFFFF, 2'b11);
    cyc();
    chk("unmapped_led", 32'(led_out), 32'h0);
    rd(4'hF, 16'h0000);
    rd(4'd0, 16'h0000);
    rd(4'd4, 16'h0000);

    // Same-cycle read and write returns the old value
    wr(4'd0, 16'h1234, 2'b11);
    re = 1'b1; we = 1'b1; addr = 4'd0; wdata = 16'h5678; be = 2'b11;
    sb.push_back(16'h1234);
    cyc();
    re = 1'b0; we = 1'b0; be = 2'b00;
    cyc();
    rd(4'd0, 16'h5678);

    // High lane only
    wr(4'd0, 16'hABCD, 2'b10);
    rd(4'd0, 16'hAB78);
    wr(4'd1, 16'h1234, 2'b11);
    rd(4'd1, 16'h0034);
    cyc();
    chk("led_mixed", 32'(led_out), 32'h34AB78);

`ifdef LED_PWM_EN
    rd(4'd5, 16'h00FF);
    wr(4'd0, 16'hFFFF, 2'b11);
    wr(4'd1, 16'hFFFF, 2'b11);
    wr(4'd5, 16'h0040, 2'b01);
    rd(4'd5, 16'h0040);
    on = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      if (led_out == 24'hFFFFFF) on++;
    end
    chk("pwm_duty64", 32'(on), 32'd64);
    wr(4'd5, 16'h0000, 2'b01);
    cyc();
    on = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      if (led_out != 24'h0) on++;
    end
    chk("pwm_duty0", 32'(on), 32'd0);
    wr(4'd5, 16'h00FF, 2'b01);
`else
    wr(4'd5, 16'hFFFF, 2'b11);
    rd(4'd5, 16'h0000);
    wr(4'd0, 16'hFFFF, 2'b11);
    wr(4'd1, 16'hFFFF, 2'b11);
`endif

    // Reset asserted mid-operation
    waited = 0;
    while (led_out == 24'h0 && waited < 300) begin
      cyc();
      waited++;
    end
    chk("led_lit_before_rst", 32'(led_out != 24'h0), 32'h1);
    rst = 1'b1;
    cyc();
    chk("rst_mid_led", 32'(led_out), 32'h0);
    rst = 1'b0;
    cyc();
    rd(4'd0, 16'h0000);
    rd(4'd1, 16'h0000);
    chk("post_rst_led", 32'(led_out), 32'h0);

    repeat (3) cyc();
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_bank_ctrl.md
Name: led_bank_ctrl

Overview:
- Parametrised memory-mapped LED output controller; successor to the fixed 24-bit, 8/16-bit-lane LED register.
- Sits behind the MemOrIO decoder. Provides byte-enabled writes over the IO data bus, readback, and a per-LED hardware blink mask with a programmable rate.
- Optional global PWM brightness.

Parameters:
- NUM_LEDS, 24, number of LED outputs; must be a multiple of 8.
- DATA_W, 16, IO bus data width; must be a multiple of 8.
- ADDR_W, 4, word-address width of the register window.
- NW, derived = ceil(NUM_LEDS/DATA_W), number of bus words per LED-wide register.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- we  in  1  write strobe (already decoded chip select)
- re  in  1  read strobe
- addr  in  ADDR_W  word address within the LED window
- be  in  DATA_W/8  byte enables for the write
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  registered read data
- rvalid  out  1  one-cycle pulse; rdata is valid
- led_out  out  NUM_LEDS  board LED drive

Behaviour:
- Word map:
  - 0..NW-1: PATTERN words; word k holds bits [k*DATA_W +: DATA_W].
  - NW..2NW-1: BLINK mask words.
  - 2NW: RATE (16 bit).
  - 2NW+1: DUTY (8 bit, LSBs; present only with the optional feature).
  - Every other address is unmapped.
- Reset, applied on the clk edge while rst=1: PATTERN=0, BLINK=0, RATE=0, DUTY=8'hFF, prescaler=0, phase=0, led_out=0, rdata=0, rvalid=0.
- Write: each byte lane with be[i]=1 updates; lanes with be[i]=0 are unchanged.
  - Bits at or above NUM_LEDS are dropped and read back as 0.
  - Writes to unmapped addresses are ignored.
- Read: rdata and rvalid appear on the cycle after re (1-cycle latency).
  - Unmapped addresses read 0.
  - re and we to the same address in the same cycle: rdata returns the pre-write value.
- Prescaler, when RATE!=0:
  - Counts up each cycle.
  - When count==RATE: count wraps to 0 and phase toggles.
  - Blink period is 2*(RATE+1) cycles.
- RATE=0: prescaler and phase are held at 0; blinking is disabled.
- Any write to RATE clears the prescaler and phase in the same edge. A write has priority over a simultaneous wrap.
- Output, registered: led_out <= PATTERN ^ (BLINK & {NUM_LEDS{phase}}).
  - A PATTERN write is visible on led_out 1 cycle after the write edge.
- rst asserted mid-operation overrides every other event in that cycle.

Optional Feature:
- Macro: LED_PWM_EN.
- Enabled:
  - 8-bit free-running pwm_cnt, reset 0.
  - led_out <= base & {NUM_LEDS{pwm_cnt < DUTY}}.
  - DUTY=0 gives all LEDs dark.
  - Reset DUTY=8'hFF gives 255/256 on-time.
- Disabled:
  - No pwm_cnt.
  - DUTY address is unmapped (writes ignored, reads 0).
  - led_out = base.

Decomposition:
- Shared package led_pkg holds:
  - register offset constants: PATTERN_BASE, BLINK_BASE, RATE_OFS, DUTY_OFS expressed via NW;
  - reset constants RATE_RST=16'h0 and DUTY_RST=8'hFF;
  - enum typedef reg_sel_e {SEL_PATTERN, SEL_BLINK, SEL_RATE, SEL_DUTY, SEL_NONE} produced by the address decode.
- One sub-module, led_blink_timer, contains the prescaler, phase and rate-write clear.

Test Plan:
- Reset, then write PATTERN word0=16'hA5C3 with be=2'b01 -> one cycle later led_out[15:0]=16'h00C3; read word0 -> rdata=16'h00C3 with rvalid for one cycle.
- NUM_LEDS=24: write word1=16'hFFFF with be=2'b11 -> led_out[23:16]=8'hFF; read word1 returns 16'h00FF.
- PATTERN=0, BLINK=24'h00000F, RATE=3 -> led_out[3:0] toggles every 4 cycles (period 8); bits 23:4 stay 0. Rewriting RATE mid-count restarts the phase at 0.
- Unmapped addr=4'hF: write 16'hFFFF -> no state change; read returns 0 with rvalid=1.
- Same-cycle re+we to word0 (old 16'h1234, new 16'h5678) -> rdata=16'h1234; a following read returns 16'h5678.
- LED_PWM_EN, PATTERN all ones, DUTY=64 -> led_out high for exactly 64 of every 256 cycles; DUTY=0 keeps it always 0. Asserting rst mid-window gives led_out=0 on the next edge.
